oled_page_writer: RTL and testbench

// Display-data stage downstream of the OLED power-up/init sequencer. Once the panel is initialised
// (init fin -> en), it holds a 4x16 character text buffer.
// On request it streams one full frame over SPI. A frame is 4 pages x (4 addressing commands + 128 glyph column bytes).

---
 rtl/oled_page_writer_pkg.sv | 22 ++
 rtl/oled_page_writer_if.sv | 12 +
 rtl/oled_page_writer_spi_ctrl.sv | 67 ++++++
 rtl/oled_page_writer.sv | 114 +++++++++++
 tb/tb_oled_page_writer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/oled_page_writer_pkg.sv
// oled_page_writer_pkg: shared sizes, state encodings and panel command bytes for the page writer
package oled_page_writer_pkg;
  localparam int PAGES = 4;
  localparam int CHARS = 16;
  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] SET_PAGE = 8'h22;
  localparam logic [7:0] COL_LO = 8'h00;
  localparam logic [7:0] COL_HI = 8'h10;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;
  localparam logic [2:0] ST_REL = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
  localparam logic [1:0] SPI_IDLE = 2'd0;
  localparam logic [1:0] SPI_SEND = 2'd1;
  localparam logic [1:0] SPI_FIN = 2'd2;
  function automatic logic [7:0] cmd_byte(input logic [1:0] idx, input logic [1:0] page);
    return idx == 2'd0 ? SET_PAGE : idx == 2'd1 ? {6'd0, page} : idx == 2'd2 ? COL_LO : COL_HI;
  endfunction
endpackage

// File: rtl/oled_page_writer_if.sv
// oled_page_writer_if: control, text-buffer write, font ROM and panel pins of the page writer
interface oled_page_writer_if;
  logic en, upd, clr, wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data, font_char, font_data;
  logic [2:0] font_col;
  logic cs, sdo, sclk, dc, busy, done;
  modport master(output en, upd, clr, wr_en, wr_addr, wr_data, font_data,
                 input font_char, font_col, cs, sdo, sclk, dc, busy, done);
  modport slave(input en, upd, clr, wr_en, wr_addr, wr_data, font_data,
                output font_char, font_col, cs, sdo, sclk, dc, busy, done);
endinterface

// File: rtl/oled_page_writer_spi_ctrl.sv
// spi_ctrl: sends one byte MSB first (sclk idles high, sdo changes on falling edge), fin held until spi_en drops
module spi_ctrl
  import oled_page_writer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_en,
  input  logic [7:0] spi_data,
  output logic       spi_fin,
  output logic       cs,
  output logic       sdo,
  output logic       sclk
);
  logic [1:0] st_q, st_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] bits_q, bits_d;
  logic cs_q, cs_d, sdo_q, sdo_d, sclk_q, sclk_d;
  assign spi_fin = st_q == SPI_FIN;
  assign cs = cs_q;
  assign sdo = sdo_q;
  assign sclk = sclk_q;
  always_comb begin
    st_d = st_q;
    sr_d = sr_q;
    bits_d = bits_q;
    cs_d = cs_q;
    sdo_d = sdo_q;
    sclk_d = sclk_q;
    if (st_q == SPI_IDLE && spi_en) begin
      st_d = SPI_SEND;
      sr_d = spi_data;
      bits_d = 3'd0;
      cs_d = 1'b0;
      sdo_d = spi_data[7];
    end else if (st_q == SPI_SEND && sclk_q) begin
      sclk_d = 1'b0;
      if (bits_q != 3'd0) begin
        sr_d = {sr_q[6:0], 1'b0};
        sdo_d = sr_q[6];
      end
    end else if (st_q == SPI_SEND) begin
      sclk_d = 1'b1;
      bits_d = bits_q + 3'd1;
      st_d = bits_q == 3'd7 ? SPI_FIN : SPI_SEND;
    end else if (st_q == SPI_FIN) begin
      cs_d = 1'b1;
      st_d = spi_en ? SPI_FIN : SPI_IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= SPI_IDLE;
      sr_q <= 8'h00;
      bits_q <= 3'd0;
      cs_q <= 1'b1;
      sdo_q <= 1'b0;
      sclk_q <= 1'b1;
    end else begin
      st_q <= st_d;
      sr_q <= sr_d;
      bits_q <= bits_d;
      cs_q <= cs_d;
      sdo_q <= sdo_d;
      sclk_q <= sclk_d;
    end
  end
endmodule

// File: rtl/oled_page_writer.sv
// oled_page_writer: holds a 4x16 text buffer and streams it as a 4-page frame of commands and glyph columns over SPI
module oled_page_writer
  import oled_page_writer_pkg::*;
(
  input logic clk,
  input logic rst,
  oled_page_writer_if.slave bus
);
  logic [2:0] st_q, st_d;
  logic [1:0] page_q, page_d;
  logic [6:0] cnt_q, cnt_d;
  logic clrm_q, clrm_d, dc_q, dc_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] spi_data_q, spi_data_d;
  logic [7:0] txt_q [PAGES*CHARS];
  logic [7:0] txt_d [PAGES*CHARS];
  logic spi_en, spi_fin;
  // CMD and DATA are the load step of the byte handshake; the glyph is fetched there
  assign bus.font_char = st_q == ST_DATA ? txt_q[{page_q, cnt_q[6:3]}] : 8'h00;
  assign bus.font_col = st_q == ST_DATA ? cnt_q[2:0] : 3'd0;
  assign spi_en = st_q == ST_START || st_q == ST_WAIT;
  assign bus.dc = dc_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  always_comb begin
    txt_d = txt_q;
    if (bus.wr_en) txt_d[bus.wr_addr] = bus.wr_data;
    st_d = st_q;
    page_d = page_q;
    cnt_d = cnt_q;
    clrm_d = clrm_q;
    dc_d = dc_q;
    busy_d = busy_q;
    done_d = done_q;
    spi_data_d = spi_data_q;
    case (st_q)
      ST_IDLE: begin
        dc_d = 1'b0;
        if (bus.en && (bus.upd || bus.clr)) begin
          st_d = ST_CMD;
          clrm_d = bus.clr;
          busy_d = 1'b1;
          done_d = 1'b0;
          page_d = 2'd0;
          cnt_d = 7'd0;
        end
      end
      ST_CMD: begin
        spi_data_d = cmd_byte(cnt_q[1:0], page_q);
        dc_d = 1'b0;
        st_d = ST_START;
      end
      ST_DATA: begin
        spi_data_d = clrm_q ? 8'h00 : bus.font_data;
        dc_d = 1'b1;
        st_d = ST_START;
      end
      ST_START: st_d = ST_WAIT;
      ST_WAIT: st_d = spi_fin ? ST_REL : ST_WAIT;
      ST_REL: begin
        if (!bus.en) begin
          st_d = ST_IDLE;
          busy_d = 1'b0;
          done_d = 1'b0;
          page_d = 2'd0;
          cnt_d = 7'd0;
        end else if (!dc_q) begin
          cnt_d = cnt_q == 7'd3 ? 7'd0 : cnt_q + 7'd1;
          st_d = cnt_q == 7'd3 ? ST_DATA : ST_CMD;
        end else begin
          cnt_d = cnt_q + 7'd1;
          page_d = cnt_q == 7'd127 ? page_q + 2'd1 : page_q;
          st_d = cnt_q != 7'd127 ? ST_DATA : page_q == 2'd3 ? ST_DONE : ST_CMD;
          busy_d = !(cnt_q == 7'd127 && page_q == 2'd3);
          done_d = cnt_q == 7'd127 && page_q == 2'd3;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE;
      page_q <= 2'd0;
      cnt_q <= 7'd0;
      clrm_q <= 1'b0;
      dc_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      spi_data_q <= 8'h00;
      txt_q <= '{default: BLANK};
    end else begin
      st_q <= st_d;
      page_q <= page_d;
      cnt_q <= cnt_d;
      clrm_q <= clrm_d;
      dc_q <= dc_d;
      busy_q <= busy_d;
      done_q <= done_d;
      spi_data_q <= spi_data_d;
      txt_q <= txt_d;
    end
  end
  spi_ctrl u_spi (
    .clk(clk),
    .rst(rst),
    .spi_en(spi_en),
    .spi_data(spi_data_q),
    .spi_fin(spi_fin),
    .cs(bus.cs),
    .sdo(bus.sdo),
    .sclk(bus.sclk)
  );
endmodule

// File: tb/tb_oled_page_writer.sv
// tb_oled_page_writer: directed frames decoded off the SPI pins and compared with a text-buffer/font model
module tb_oled_page_writer;
  logic clk = 1'b0;
  logic rst;
  oled_page_writer_if bus();
  oled_page_writer dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.font_data = {bus.font_char[4:0], bus.font_col};
  int n_cmp = 0, n_bad = 0;
  logic [7:0] rx_b[$];
  logic rx_dc[$];
  int ncs = 0, nb = 0, dcbad = 0;
  logic [7:0] sh = 8'h00;
  logic psclk = 1'b1, pcs = 1'b1, pdc = 1'b0;
  logic [7:0] mbuf [64];
  always @(negedge clk) begin
    if (!bus.cs && pcs) begin
      ncs <= ncs + 1;
      nb <= 0;
    end else if (!bus.cs && bus.sclk && !psclk) begin
      sh <= {sh[6:0], bus.sdo};
      nb <= nb + 1;
      if (nb == 7) begin
        rx_b.push_back({sh[6:0], bus.sdo});
        rx_dc.push_back(bus.dc);
      end
    end
    if (!bus.cs && bus.dc != pdc) dcbad <= dcbad + 1;
    psclk <= bus.sclk;
    pcs <= bus.cs;
    pdc <= bus.dc;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic u, input logic c);
    @(negedge clk);
    bus.upd = u;
    bus.clr = c;
    @(negedge clk);
    bus.upd = 1'b0;
    bus.clr = 1'b0;
  endtask
  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    mbuf[a] = d;
  endtask
  task automatic wait_idle(input string tag);
    int t = 0;
    while (bus.busy && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, 32'(t < 20000), 1);
    tick(4);
  endtask
  function automatic logic [8:0] exp_byte(input int i, input logic clrm);
    int p = i / 132;
    int k = i % 132;
    int c = k - 4;
    logic [7:0] ch;
    if (k < 4) return {1'b0, k == 0 ? 8'h22 : k == 1 ? p[7:0] : k == 2 ? 8'h00 : 8'h10};
    ch = mbuf[p * 16 + c / 8];
    return {1'b1, clrm ? 8'h00 : {ch[4:0], c[2:0]}};
  endfunction
  task automatic chk_frame(input string tag, input int n, input logic clrm);
    int bad = 0;
    chk({tag, "_count"}, rx_b.size(), n);
    for (int i = 0; i < n && i < rx_b.size(); i++)
      if ({rx_dc[i], rx_b[i]} !== exp_byte(i, clrm)) bad++;
    chk({tag, "_bytes_bad"}, bad, 0);
  endtask
  task automatic frame(input string tag, input logic u, input logic c);
    rx_b.delete();
    rx_dc.delete();
    pulse(u, c);
    chk({tag, "_busy_start"}, bus.busy, 1);
    chk({tag, "_done_start"}, bus.done, 0);
    wait_idle(tag);
    chk({tag, "_done"}, bus.done, 1);
    chk_frame(tag, 528, c);
  endtask
  initial begin
    int idle_bad = 0, base = 0, t = 0;
    for (int i = 0; i < 64; i++) mbuf[i] = 8'h20;
    bus.en = 1'b0;
    bus.upd = 1'b0;
    bus.clr = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = 6'd0;
    bus.wr_data = 8'h00;
    rst = 1'b1;
    #23;
    chk("rst_cs", bus.cs, 1);
    chk("rst_sclk", bus.sclk, 1);
    chk("rst_sdo", bus.sdo, 0);
    chk("rst_dc", bus.dc, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_font_char", bus.font_char, 0);
    chk("rst_font_col", bus.font_col, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.cs !== 1'b1 || bus.dc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) idle_bad++;
    end
    chk("idle_1000", idle_bad, 0);
    chk("idle_no_cs", ncs, 0);
    rx_b.delete();
    rx_dc.delete();
    pulse(1'b1, 1'b0);
    chk("f1_busy_start", bus.busy, 1);
    tick(300);
    pulse(1'b1, 1'b0);
    wait_idle("f1");
    chk("f1_done", bus.done, 1);
    chk("f1_busy_end", bus.busy, 0);
    chk_frame("f1", 528, 1'b0);
    chk("f1_hdr0", rx_b[0], 8'h22);
    chk("f1_hdr3", rx_b[3], 8'h10);
    chk("f1_dc_hdr", rx_dc[2], 0);
    chk("f1_col0", rx_b[4], 8'h00);
    chk("f1_col7", rx_b[11], 8'h07);
    chk("f1_dc_data", rx_dc[4], 1);
    tick(10);
    chk("f1_done_held", bus.done, 1);
    wr(6'd17, 8'h41);
    frame("f2", 1'b1, 1'b0);
    chk("f2_p1_hdr1", rx_b[133], 8'h01);
    chk("f2_p1_col8", rx_b[144], 8'h08);
    chk("f2_p1_col15", rx_b[151], 8'h0f);
    frame("f3", 1'b1, 1'b1);
    chk("f3_p1_col8", rx_b[144], 8'h00);
    chk("f3_hdr0", rx_b[0], 8'h22);
    frame("f4", 1'b1, 1'b0);
    chk("f4_p1_col15", rx_b[151], 8'h0f);
    rx_b.delete();
    rx_dc.delete();
    base = ncs;
    pulse(1'b1, 1'b0);
    t = 0;
    while (ncs - base < 319 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("ab_reach_timeout", 32'(t < 20000), 1);
    bus.en = 1'b0;
    wait_idle("ab");
    tick(100);
    chk("ab_busy", bus.busy, 0);
    chk("ab_done", bus.done, 0);
    chk("ab_bytes_started", ncs - base, 319);
    chk_frame("ab", 319, 1'b0);
    base = ncs;
    pulse(1'b1, 1'b0);
    tick(50);
    chk("en0_ignored_busy", bus.busy, 0);
    chk("en0_ignored_cs", ncs - base, 0);
    bus.en = 1'b1;
    frame("f6", 1'b1, 1'b0);
    base = ncs;
    pulse(1'b1, 1'b0);
    t = 0;
    while (!(ncs - base >= 3 && bus.cs == 1'b0 && bus.sclk == 1'b0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("rst_mid_timeout", 32'(t < 2000), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cs", bus.cs, 1);
    chk("rst_mid_sclk", bus.sclk, 1);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_dc", bus.dc, 0);
    @(negedge clk);
    rst = 1'b0;
    base = ncs;
    tick(40);
    chk("post_rst_idle_busy", bus.busy, 0);
    chk("post_rst_idle_done", bus.done, 0);
    chk("post_rst_no_cs", ncs - base, 0);
    chk("dc_stable_cs_low", dcbad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
